data_mem_resp: RTL and testbench
================================

Name: data_mem_resp

Overview:
- Responder end of the data-memory interface driven by the MEM stage.
- Word-organised synchronous RAM with per-byte write enables and read-byte masks, returning registered read data to the WB stage one cycle after the request.
- Also detects out-of-range accesses and raises a sticky error flag.
- Byte-lane convention: bus lane 3 (bits 31:24) is the byte at address offset 00 and lane 0 (bits 7:0) is offset 11; data is stored and returned in exactly this lane order.

Parameters:
- ADDR_WIDTH, 10, number of word-index bits; capacity is 2^ADDR_WIDTH 32-bit words (4 KiB at default).
- INIT_ZERO, 1, when 1 the reset clears the array via a sequential sweep; when 0 array contents are undefined after reset.

Ports:
- cpu_clk  input  1  system clock, all state updates on rising edge
- cpu_rst  input  1  synchronous, active-high reset
- dce  input  1  access enable
- daddr  input  32  byte address; bits [1:0] ignored for word indexing
- we  input  4  byte write enables, lane i writes din[8i+7:8i]
- din  input  32  write data, already lane-arranged by requester
- dre  input  4  byte read mask, lane i returned, others zero
- dout  output  32  registered read data
- dm_busy  output  1  high while reset sweep (INIT_ZERO=1) in progress
- dm_err  output  1  sticky out-of-range flag

Behaviour:
- Reset (cpu_rst=1 at a rising edge): dout=0, dm_err=0. If INIT_ZERO=1, dm_busy=1 and the sweep counter is set to 0. If INIT_ZERO=0, dm_busy=0.
- Sweep state machine, states IDLE and CLEAR:
  - Reset enters CLEAR.
  - In CLEAR, one word is zeroed per cycle at the counter index and the counter increments.
  - After the cycle that zeroes word 2^ADDR_WIDTH-1, the next state is IDLE and dm_busy drops.
  - Sweep length is exactly 2^ADDR_WIDTH cycles after reset deasserts.
  - While in CLEAR, requests are ignored: no write, dout=0.
  - Reset asserted mid-sweep restarts the sweep at index 0.
- In-range test: daddr[31:ADDR_WIDTH+2]==0. Word index = daddr[ADDR_WIDTH+1:2].
- Write (IDLE, dce=1, we!=0, in range): on the clock edge, each lane with we[i]=1 is updated; other lanes are unchanged. Single-cycle, no handshake.
- Read (IDLE, dce=1, dre!=0, in range): dout at the next edge = stored word AND the lane mask expanded from dre. Latency is 1 cycle.
- Read and write in the same cycle at the same index: read-before-write. dout returns the old contents and the array takes the new bytes.
- dce=1 with we=0 and dre=0: no-op, dout=0.
- dce=0: no access, dout=0 at the next edge. Stale data is never held.
- Out of range with dce=1 and (we or dre nonzero): no array change, dout=0, dm_err set to 1. dm_err stays 1 until cpu_rst.
- we bits with dce=0: ignored.
- Address wrap: none. Indices beyond capacity are only reachable through the out-of-range path.

Optional Feature:
- Macro DMEM_STAT_EN.
- When defined, adds two outputs:
  - rd_cnt (32): counts in-range reads accepted in IDLE.
  - wr_cnt (32): counts in-range writes accepted in IDLE.
- Both counters clear on cpu_rst and saturate at 32'hFFFFFFFF.
- A same-cycle read plus write increments both counters.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset sweep (INIT_ZERO=1, ADDR_WIDTH=4): release cpu_rst, then read word 5 -> dm_busy high exactly 16 cycles; after it drops, dout=32'h0 one cycle after the read.
- Full-word write/read: write daddr=32'h10, we=4'hF, din=32'h78563412; next cycle read with dre=4'hF -> dout=32'h78563412 one cycle later.
- Byte write masking: after the previous write, write daddr=32'h12, we=4'b0010, din=32'hAAAAAAAA, then read dre=4'hF -> dout=32'h7856AA12. Then read dre=4'b0010 -> dout=32'h0000AA00.
- Same-cycle read/write: word 0x20 holds 32'h11111111; in one cycle drive we=4'hF with din=32'h22222222 and dre=4'hF -> dout=32'h11111111; a following read -> 32'h22222222.
- Out of range (ADDR_WIDTH=10): write daddr=32'h1000, we=4'hF -> no array change, dm_err=1 next cycle and stays 1 across later legal accesses until cpu_rst.
- DMEM_STAT_EN: 3 in-range reads, 2 in-range writes, 1 out-of-range read -> rd_cnt=3, wr_cnt=2. Assert cpu_rst -> both 0.

Source files
------------

// File: rtl/data_mem_resp.sv
// Purpose : data-memory responder for the MEM stage; word RAM with byte write enables,
//           byte read masks, out-of-range detection and an optional zeroing sweep on reset.
// Latency : read data is registered, valid one cycle after the request; writes land on the request edge.
// Backpressure: none; requests made while dm_busy is high are dropped (no write, dout=0).
//
// Ports:
//   cpu_clk  - clock, all state on the rising edge
//   cpu_rst  - synchronous active-high reset
//   dce      - access enable
//   daddr    - byte address; [1:0] ignored, [ADDR_WIDTH+1:2] is the word index,
//              anything set above that is out of range
//   we       - per-lane write enables (lane 3 = bits 31:24 = byte offset 00)
//   din      - lane-arranged write data
//   dre      - per-lane read mask; unselected lanes read back as zero
//   dout     - registered read data, zero whenever no valid read was accepted
//   dm_busy  - high while the reset sweep is clearing the array
//   dm_err   - sticky out-of-range flag, cleared only by cpu_rst
//   rd_cnt / wr_cnt - saturating counters of accepted in-range reads/writes,
//              present only when the DMEM_STAT_EN macro is defined
module data_mem_resp #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter bit          INIT_ZERO  = 1'b1
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        dce,
    input  logic [31:0] daddr,
    input  logic [3:0]  we,
    input  logic [31:0] din,
    input  logic [3:0]  dre,
    output logic [31:0] dout,
    output logic        dm_busy,
    output logic        dm_err
`ifdef DMEM_STAT_EN
    ,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
`endif
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0] mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   sweep_cnt_q;
    logic                    busy_q;
    logic [31:0]             dout_q, dout_d;
    logic                    err_q, err_d;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                    in_range;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic                    req_idle;
    logic                    wr_acc;
    logic                    rd_acc;
    logic                    oor_hit;
    logic [31:0]             rd_mask;
    logic [1:0]              unused_byte_off;

    assign unused_byte_off = daddr[1:0];

    assign in_range = (daddr[31:ADDR_WIDTH+2] == '0);
    assign word_idx = daddr[ADDR_WIDTH+1:2];
    assign req_idle = (state_q == ST_IDLE) && dce;
    assign wr_acc   = req_idle && in_range && (we != 4'b0000);
    assign rd_acc   = req_idle && in_range && (dre != 4'b0000);
    // An out-of-range attempt only counts if it would actually have touched the array.
    assign oor_hit  = req_idle && !in_range && ((we | dre) != 4'b0000);

    always_comb begin
        rd_mask = '0;
        for (int i = 0; i < 4; i++) begin
            rd_mask[8*i +: 8] = {8{dre[i]}};
        end
    end

    // ------------------------------------------------------------------
    // Unified array write port: the sweep and normal writes never overlap,
    // since requests are ignored while clearing.
    // ------------------------------------------------------------------
    logic                  arr_we;
    logic [3:0]            arr_be;
    logic [ADDR_WIDTH-1:0] arr_idx;
    logic [31:0]           arr_wdat;

    always_comb begin
        arr_we   = 1'b0;
        arr_be   = 4'b0000;
        arr_idx  = word_idx;
        arr_wdat = din;
        if (state_q == ST_CLEAR && !cpu_rst) begin
            arr_we   = 1'b1;
            arr_be   = 4'b1111;
            arr_idx  = sweep_cnt_q;
            arr_wdat = '0;
        end else if (wr_acc && !cpu_rst) begin
            arr_we   = 1'b1;
            arr_be   = we;
            arr_idx  = word_idx;
            arr_wdat = din;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (arr_we) begin
            for (int i = 0; i < 4; i++) begin
                if (arr_be[i]) begin
                    mem_q[arr_idx][8*i +: 8] <= arr_wdat[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sweep FSM
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            sweep_cnt_q <= '0;
            if (INIT_ZERO) begin
                state_q <= ST_CLEAR;
                busy_q  <= 1'b1;
            end else begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    sweep_cnt_q <= sweep_cnt_q + 1'b1;
                    // Leaving on the edge that clears the last word keeps the
                    // sweep at exactly DEPTH cycles.
                    if (sweep_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read data and error flag
    // ------------------------------------------------------------------
    // The array is read before this edge's write lands, which gives
    // read-before-write on a same-index read/write.
    always_comb begin
        dout_d = '0;
        if (rd_acc) begin
            dout_d = mem_q[word_idx] & rd_mask;
        end
    end

    assign err_d = err_q | oor_hit;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            dout_q <= '0;
            err_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            err_q  <= err_d;
        end
    end

    assign dout    = dout_q;
    assign dm_busy = busy_q;
    assign dm_err  = err_q;

`ifdef DMEM_STAT_EN
    // ------------------------------------------------------------------
    // Access statistics
    // ------------------------------------------------------------------
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (rd_acc && (rd_cnt_q != 32'hFFFF_FFFF)) begin
            rd_cnt_d = rd_cnt_q + 32'd1;
        end
        if (wr_acc && (wr_cnt_q != 32'hFFFF_FFFF)) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp (ADDR_WIDTH=4, INIT_ZERO=1): 16-word array,
// byte address 0x40 is the first out-of-range location.
module tb_data_mem_resp;

    logic        cpu_clk;
    logic        cpu_rst;
    logic        dce;
    logic [31:0] daddr;
    logic [3:0]  we;
    logic [31:0] din;
    logic [3:0]  dre;
    logic [31:0] dout;
    logic        dm_busy;
    logic        dm_err;
`ifdef DMEM_STAT_EN
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;
`endif

    int pass_cnt = 0;
    int total    = 0;

    data_mem_resp #(.ADDR_WIDTH(4), .INIT_ZERO(1'b1)) dut (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .dce     (dce),
        .daddr   (daddr),
        .we      (we),
        .din     (din),
        .dre     (dre),
        .dout    (dout),
        .dm_busy (dm_busy),
        .dm_err  (dm_err)
`ifdef DMEM_STAT_EN
        ,
        .rd_cnt  (rd_cnt),
        .wr_cnt  (wr_cnt)
`endif
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive one request, clock it in, and return #1 after the edge.
    task automatic cyc(input logic c, input logic [31:0] a, input logic [3:0] w,
                       input logic [31:0] d, input logic [3:0] r);
        dce   = c;
        daddr = a;
        we    = w;
        din   = d;
        dre   = r;
        @(posedge cpu_clk);
        #1;
    endtask

    // Hold a request on the bus while the sweep runs; returns busy cycle
    // count and whether dout ever went non-zero.
    task automatic run_sweep(output int n, output logic dout_seen);
        n         = 0;
        dout_seen = 1'b0;
        dce   = 1'b1;
        daddr = 32'h14;
        we    = 4'hF;
        din   = 32'hFFFF_FFFF;
        dre   = 4'hF;
        while (dm_busy && n < 100) begin
            @(posedge cpu_clk);
            #1;
            n++;
            if (dout !== 32'h0) dout_seen = 1'b1;
        end
    endtask

    initial begin
        int   n;
        logic seen;

        // ---------------- reset state ----------------
        cpu_rst = 1'b1;
        cyc(1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
        cyc(1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
        check("rst_dout", dout, 32'h0);
        check("rst_err", {31'b0, dm_err}, 32'h0);
        check("rst_busy", {31'b0, dm_busy}, 32'h1);

        // ---------------- reset sweep ----------------
        cpu_rst = 1'b0;
        run_sweep(n, seen);
        check("sweep_len", n, 32'd16);
        check("sweep_dout_zero", {31'b0, seen}, 32'h0);
        cyc(1'b1, 32'h14, 4'h0, 32'h0, 4'hF);
        check("sweep_word5_zero", dout, 32'h0);
        check("sweep_no_err", {31'b0, dm_err}, 32'h0);

        // ---------------- full word write/read ----------------
        cyc(1'b1, 32'h10, 4'hF, 32'h7856_3412, 4'h0);
        check("write_only_dout", dout, 32'h0);
        cyc(1'b1, 32'h10, 4'h0, 32'h0, 4'hF);
        check("full_rd", dout, 32'h7856_3412);

        // ---------------- byte write masking ----------------
        cyc(1'b1, 32'h12, 4'b0010, 32'hAAAA_AAAA, 4'h0);
        cyc(1'b1, 32'h12, 4'h0, 32'h0, 4'hF);
        check("byte_wr_rd", dout, 32'h7856_AA12);
        cyc(1'b1, 32'h10, 4'h0, 32'h0, 4'b0010);
        check("lane1_mask", dout, 32'h0000_AA00);
        cyc(1'b1, 32'h10, 4'h0, 32'h0, 4'b1001);
        check("lane30_mask", dout, 32'h7800_0012);

        // ---------------- no stale data ----------------
        cyc(1'b0, 32'h10, 4'h0, 32'h0, 4'hF);
        check("dce0_dout", dout, 32'h0);
        cyc(1'b1, 32'h10, 4'h0, 32'h0, 4'h0);
        check("noop_dout", dout, 32'h0);

        // ---------------- same-cycle read/write ----------------
        cyc(1'b1, 32'h20, 4'hF, 32'h1111_1111, 4'h0);
        cyc(1'b1, 32'h20, 4'hF, 32'h2222_2222, 4'hF);
        check("rbw_old", dout, 32'h1111_1111);
        cyc(1'b1, 32'h20, 4'h0, 32'h0, 4'hF);
        check("rbw_new", dout, 32'h2222_2222);

        // ---------------- we with dce=0 ignored ----------------
        cyc(1'b0, 32'h10, 4'hF, 32'h0, 4'h0);
        cyc(1'b1, 32'h10, 4'h0, 32'h0, 4'hF);
        check("dce0_we_ignored", dout, 32'h7856_AA12);

        // ---------------- last word boundary ----------------
        cyc(1'b1, 32'h3C, 4'hF, 32'hDEAD_BEEF, 4'h0);
        cyc(1'b1, 32'h3F, 4'h0, 32'h0, 4'hF);
        check("last_word", dout, 32'hDEAD_BEEF);
        check("last_word_no_err", {31'b0, dm_err}, 32'h0);

        // ---------------- out of range ----------------
        cyc(1'b1, 32'h40, 4'hF, 32'h1234_5678, 4'h0);
        check("oor_err_set", {31'b0, dm_err}, 32'h1);
        cyc(1'b1, 32'h00, 4'h0, 32'h0, 4'hF);
        check("oor_no_wrap", dout, 32'h0);
        check("oor_err_sticky", {31'b0, dm_err}, 32'h1);
        cyc(1'b1, 32'h8000_0010, 4'h0, 32'h0, 4'hF);
        check("oor_rd_dout", dout, 32'h0);
        cyc(1'b1, 32'h10, 4'h0, 32'h0, 4'hF);
        check("oor_legal_after", dout, 32'h7856_AA12);
        check("oor_err_sticky2", {31'b0, dm_err}, 32'h1);

        // ---------------- reset mid-sweep restarts ----------------
        cpu_rst = 1'b1;
        cyc(1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
        check("rst2_err_clr", {31'b0, dm_err}, 32'h0);
        cpu_rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
        cpu_rst = 1'b1;
        cyc(1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
        cpu_rst = 1'b0;
        run_sweep(n, seen);
        check("resweep_len", n, 32'd16);
        cyc(1'b1, 32'h10, 4'h0, 32'h0, 4'hF);
        check("resweep_cleared", dout, 32'h0);

`ifdef DMEM_STAT_EN
        // ---------------- statistics ----------------
        cpu_rst = 1'b1;
        cyc(1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
        check("stat_rst_rd", rd_cnt, 32'd0);
        check("stat_rst_wr", wr_cnt, 32'd0);
        cpu_rst = 1'b0;
        run_sweep(n, seen);
        check("stat_sweep_rd", rd_cnt, 32'd0);
        cyc(1'b1, 32'h04, 4'hF, 32'h0000_0001, 4'h0);
        cyc(1'b1, 32'h04, 4'h0, 32'h0, 4'hF);
        cyc(1'b1, 32'h08, 4'hF, 32'h0000_0002, 4'hF);
        cyc(1'b1, 32'h08, 4'h0, 32'h0, 4'h0);
        cyc(1'b1, 32'h80, 4'h0, 32'h0, 4'hF);
        cyc(1'b1, 32'h0C, 4'h0, 32'h0, 4'h1);
        check("stat_rd", rd_cnt, 32'd3);
        check("stat_wr", wr_cnt, 32'd2);
        cpu_rst = 1'b1;
        cyc(1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
        check("stat_clr_rd", rd_cnt, 32'd0);
        check("stat_clr_wr", wr_cnt, 32'd0);
        cpu_rst = 1'b0;
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
